// File: rtl/sram_l1_pkg.sv
// Shared types and default widths for the L1 SRAM arbiter.
// Optional read watchdog: SRAM_ARB_TIMEOUT_EN.
package sram_l1_pkg;

  localparam int SRAM_ADDR_W  = 11;
  localparam int SRAM_DATA_W  = 64;
  localparam int SRAM_WMASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_RESP
  } arb_state_t;

  typedef struct packed {
    logic [1:0]              gnt;
    logic                    we;
    logic [SRAM_ADDR_W-1:0]  addr;
    logic [SRAM_DATA_W-1:0]  wdata;
    logic [SRAM_WMASK_W-1:0] wmask;
  } sram_req_t;

endpackage

// File: rtl/sram_l1_rr_arb2.sv
// Two-way round-robin picker: one-hot grant, the requester
// not granted last wins a tie.
module sram_l1_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_valid)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_l1_arbiter.sv
// Two-requester arbiter in front of a single-port L1 SRAM.
// Define SRAM_ARB_TIMEOUT_EN to enable the read watchdog.
module sram_l1_arbiter
  import sram_l1_pkg::*;
#(
  parameter int ADDR_WIDTH     = SRAM_ADDR_W,
  parameter int DATA_WIDTH     = SRAM_DATA_W,
  parameter int NUM_WMASKS     = SRAM_WMASK_W,
  parameter int WRITE_WAIT     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_we,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0][NUM_WMASKS-1:0] req_wmask,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       mem_csb,
  output logic                       mem_web,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [NUM_WMASKS-1:0]      mem_wmask,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_ready
);

  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > WRITE_WAIT) ? TIMEOUT_CYCLES : WRITE_WAIT;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  arb_state_t            r_state;
  sram_req_t             r_req;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last;
  logic                  r_csb;
  logic [1:0]            r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [1:0]            w_gnt;
  logic                  w_sel;
  logic                  w_to;

  sram_l1_rr_arb2 u_rr (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_gnt   (w_gnt)
  );

  assign w_sel = w_gnt[1];

`ifdef SRAM_ARB_TIMEOUT_EN
  assign w_to = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_to = 1'b0;
`endif

  assign req_ready = (r_state == ST_IDLE) ? w_gnt : 2'b00;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mem_csb   = r_csb;
  assign mem_web   = r_csb | ~r_req.we;
  assign mem_addr  = ADDR_WIDTH'(r_req.addr);
  assign mem_wdata = DATA_WIDTH'(r_req.wdata);
  assign mem_wmask = NUM_WMASKS'(r_req.wmask);

  // r_last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_csb       <= 1'b1;
      r_rsp_valid <= 2'b00;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      unique case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_req.gnt   <= w_gnt;
            r_req.we    <= req_we[w_sel];
            r_req.addr  <= SRAM_ADDR_W'(req_addr[w_sel]);
            r_req.wdata <= SRAM_DATA_W'(req_wdata[w_sel]);
            r_req.wmask <= SRAM_WMASK_W'(req_wmask[w_sel]);
            r_cnt       <= '0;
            r_csb       <= 1'b0;
            r_state     <= req_we[w_sel] ? ST_WR_WAIT : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_ready) begin
            r_rdata     <= mem_rdata;
            r_err       <= 1'b0;
            r_csb       <= 1'b1;
            r_rsp_valid <= r_req.gnt;
            r_state     <= ST_RESP;
          end else if (w_to) begin
            r_rdata     <= '0;
            r_err       <= 1'b1;
            r_csb       <= 1'b1;
            r_rsp_valid <= r_req.gnt;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (r_cnt == CNT_W'(WRITE_WAIT - 1)) begin
            r_err       <= 1'b0;
            r_csb       <= 1'b1;
            r_rsp_valid <= r_req.gnt;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_last  <= r_req.gnt[1];
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_l1_arbiter.sv
// Directed bench for sram_l1_arbiter; honours SRAM_ARB_TIMEOUT_EN.
module tb_sram_l1_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][10:0] req_addr;
  logic [1:0][63:0] req_wdata;
  logic [1:0][7:0]  req_wmask;
  logic [1:0]       rsp_valid;
  logic [63:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_csb;
  logic             mem_web;
  logic [10:0]      mem_addr;
  logic [63:0]      mem_wdata;
  logic [7:0]       mem_wmask;
  logic [63:0]      mem_rdata;
  logic             mem_ready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_l1_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_csb   (mem_csb),
    .mem_web   (mem_web),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // read on requester r; memory answers on wait cycle w
  task automatic rd(input int r, input logic [10:0] a,
                    input logic [63:0] d, input int w);
    logic [1:0] m;
    m = 2'(1 << r);
    @(negedge clk);
    req_valid   = m;
    req_we      = 2'b00;
    req_addr[r] = a;
    #1;
    chk("rd_ready", 64'(req_ready), 64'(m));
    chk("rd_idle_csb", 64'(mem_csb), 64'd1);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("rd_wait", 64'({rsp_valid, mem_csb, mem_web, mem_addr}),
          64'({2'b00, 1'b0, 1'b1, a}));
      if (k == w) begin
        mem_ready = 1'b1;
        mem_rdata = d;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk("rd_rsp", 64'(rsp_valid), 64'(m));
    chk("rd_data", rsp_rdata, d);
    chk("rd_err", 64'(rsp_err), 64'd0);
    chk("rd_rsp_csb", 64'(mem_csb), 64'd1);
    @(negedge clk);
    #1;
    chk("rd_rsp_once", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0] exp_g [4];
    int n;
    bit seen;

    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_csb", 64'(mem_csb), 64'd1);
    chk("rst_web", 64'(mem_web), 64'd1);
    chk("rst_zero", 64'({req_ready, rsp_valid, rsp_err,
                         mem_addr, mem_wmask}), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd(0, 11'h005, 64'hDEAD_BEEF_0123_4567, 12);

    @(negedge clk);
    req_valid    = 2'b10;
    req_we       = 2'b10;
    req_addr[1]  = 11'h3FF;
    req_wmask[1] = 8'h0F;
    req_wdata[1] = 64'hA5A5_5A5A_1234_5678;
    #1;
    chk("wr_ready", 64'(req_ready), 64'd2);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("wr_wait", 64'({rsp_valid, mem_csb, mem_web}), 64'd0);
      if (k == 1) begin
        chk("wr_addr", 64'(mem_addr), 64'h3FF);
        chk("wr_mask", 64'(mem_wmask), 64'h0F);
        chk("wr_data", mem_wdata, 64'hA5A5_5A5A_1234_5678);
      end
    end
    @(negedge clk);
    #1;
    chk("wr_rsp", 64'(rsp_valid), 64'd2);
    chk("wr_err", 64'(rsp_err), 64'd0);
    chk("wr_csb", 64'(mem_csb), 64'd1);
    chk("wr_rdata_kept", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    req_we = 2'b00;

    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    @(negedge clk);
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_addr  = {11'h002, 11'h001};
    #1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("fair_gnt", 64'(req_ready), 64'(exp_g[t]));
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    req_we    = 2'b00;
    repeat (12) @(negedge clk);

    @(negedge clk);
    req_valid   = 2'b01;
    req_addr[0] = 11'h007;
    #1;
    chk("rr_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rr_wait_csb", 64'(mem_csb), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rr_csb_now", 64'(mem_csb), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00 || mem_csb != 1'b1) seen = 1'b1;
    end
    chk("rr_no_rsp", 64'(seen), 64'd0);
    chk("rr_rdata", rsp_rdata, 64'd0);

    rd(1, 11'h123, 64'h0BAD_CAFE_5555_AAAA, 3);

    @(negedge clk);
    req_valid   = 2'b01;
    req_we      = 2'b00;
    req_addr[0] = 11'h009;
    #1;
    chk("to_ready", 64'(req_ready), 64'd1);
    n = 0;
    seen = 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
    while (n < 250) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n++;
      if (rsp_valid != 2'b00) break;
    end
    chk("to_lat", 64'(n), 64'd65);
    chk("to_rsp", 64'(rsp_valid), 64'd1);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_rdata", rsp_rdata, 64'd0);
`else
    repeat (200) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    chk("no_to_rsp", 64'(seen), 64'd0);
    chk("no_to_csb", 64'(mem_csb), 64'd0);
    chk("no_to_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    rd(0, 11'h02A, 64'h0123_4567_89AB_CDEF, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sram_l1_arbiter.md
SRAM_L1_ARBITER -- requirements
Module: sram_l1_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning SRAM data width.
REQ-003 SHALL have parameter NUM_WMASKS, default 8, meaning byte write-mask width.
REQ-004 SHALL have parameter WRITE_WAIT, default 8, meaning cycles mem_csb is held low for a write.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning read watchdog limit (see REQ-027).
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port req_valid, input, 2, per-requester request valid.
REQ-009 SHALL have port req_ready, output, 2, per-requester accept pulse.
REQ-010 SHALL have port req_we, input, 2, per-requester 1=write / 0=read.
REQ-011 SHALL have ports req_addr [2][ADDR_WIDTH], req_wdata [2][DATA_WIDTH] and req_wmask [2][NUM_WMASKS], inputs, per-requester address, write data and byte mask.
REQ-012 SHALL have ports rsp_valid, output, 2, per-requester completion pulse; rsp_rdata, output, DATA_WIDTH, read data; rsp_err, output, 1, timeout flag.
REQ-013 SHALL have ports mem_csb, mem_web, mem_addr, mem_wdata and mem_wmask, outputs, driving the SRAM wrapper (csb and web are active-low; web=1 means read).
REQ-014 SHALL have ports mem_rdata, input, DATA_WIDTH, and mem_ready, input, 1, the SRAM wrapper read-data-valid pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT and RESP.
REQ-016 In IDLE with any req_valid set, SHALL grant one requester, pulse its req_ready for exactly that cycle, latch its we/addr/wdata/wmask, and go to RD_WAIT or WR_WAIT per req_we.
REQ-017 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; after reset requester 0 has priority.
REQ-018 mem_csb SHALL be 0 only in RD_WAIT and WR_WAIT, and 1 in IDLE and RESP; every transaction therefore starts with a fresh csb falling edge, with at least 2 csb-high cycles between transactions.
REQ-019 mem_addr, mem_wdata, mem_wmask and mem_web SHALL come from the latched request and stay stable throughout RD_WAIT/WR_WAIT.
REQ-020 In RD_WAIT, on mem_ready=1 the block SHALL capture mem_rdata into rsp_rdata and go to RESP.
REQ-021 In WR_WAIT, the block SHALL count WRITE_WAIT cycles and then go to RESP; rsp_rdata is unchanged by writes.
REQ-022 In RESP, the block SHALL assert rsp_valid[grant] for exactly one cycle, record the last grant and return to IDLE.
REQ-023 mem_ready SHALL be ignored outside RD_WAIT.
REQ-024 Requesters SHALL hold req_* stable until req_ready; a request withdrawn before grant SHALL NOT be issued.
REQ-025 Latency SHALL be: grant cycle + (memory wait) + 1 RESP cycle; back-to-back grants occur no faster than every 3 cycles plus memory wait.

Reset
REQ-026 While rst_n=0, the block SHALL enter IDLE with req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_csb=1, mem_web=1, mem_addr/wdata/wmask=0, all counters 0 and priority at requester 0; reset mid-transaction SHALL abort it with no rsp_valid.

Configuration
REQ-027 With macro SRAM_ARB_TIMEOUT_EN defined, RD_WAIT SHALL count cycles and, on reaching TIMEOUT_CYCLES without mem_ready, go to RESP with rsp_err=1 and rsp_rdata=0; rsp_err SHALL be 0 for normal completions.
REQ-028 Without SRAM_ARB_TIMEOUT_EN, RD_WAIT SHALL wait indefinitely and rsp_err SHALL be tied to 0; the port list is identical in both builds.

Structure
REQ-029 Shared package sram_l1_pkg SHALL hold the ADDR/DATA/WMASK width constants, the FSM state enum typedef and the latched-request struct typedef.
REQ-030 Round-robin selection SHALL be a sub-module sram_l1_rr_arb2 (2 valids plus last-grant in, one-hot grant out, combinational).

Verification
REQ-031 Bench SHALL check reset: rst_n low -> mem_csb=1, mem_web=1, all other outputs 0.
REQ-032 Bench SHALL check a single read: read on req 0 at addr 0x005, model returns 0xDEADBEEF01234567 with mem_ready 12 cycles later -> rsp_valid[0] one cycle after mem_ready, rsp_rdata matching, mem_csb low exactly during the wait.
REQ-033 Bench SHALL check a write: req 1 writes addr 0x3FF with wmask 0x0F -> mem_web=0 and mem_csb=0 for 8 cycles, then rsp_valid[1]=1 and rsp_err=0.
REQ-034 Bench SHALL check fairness: both requesters continuously valid for 4 transactions -> grant order 0,1,0,1.
REQ-035 Bench SHALL check reset mid-read: rst_n pulsed in RD_WAIT -> mem_csb=1 immediately, a later mem_ready is ignored and no rsp_valid occurs.
REQ-036 Bench SHALL check the timeout: with SRAM_ARB_TIMEOUT_EN and no mem_ready -> after 64 cycles rsp_valid with rsp_err=1 and rsp_rdata=0; without the macro, still in RD_WAIT at 200 cycles.
